// File: rtl/fir_out_requant_fifo.sv
// fir_out_requant_fifo
//   Output stage for the FIR family. It requantizes a signed Q3.21 filter
//   result to Q1.15 using round-half-up and saturation, then buffers the
//   result in a small FIFO toward the DAC/capture side. It also keeps sticky
//   saturation and overflow status plus a peak-magnitude tracker.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low
//   clear      : synchronous clear of sat/ovf flags, counters and peak_abs;
//                FIFO contents are untouched
//   in_valid   : FIR output strobe (no backpressure is possible upstream)
//   in_data    : signed Q3.21 sample
//   out_valid  : FIFO head valid
//   out_ready  : consumer accepts head
//   out_data   : signed Q1.15 head sample
//   level      : FIFO occupancy, 0..DEPTH
//   sat_flag   : sticky, some sample saturated
//   sat_count  : saturated samples, holds at 16'hFFFF
//   ovf_flag   : sticky, some sample dropped on a full FIFO
//   drop_count : dropped samples, holds at 16'hFFFF
//   peak_abs   : largest |sample| written into the FIFO (|-32768| -> 32767)
//
// Handshake: a head transfer happens on a rising edge where
// out_valid && out_ready. While out_valid && !out_ready, out_valid and
// out_data stay stable. The input side has no ready signal. A sample that
// finds the FIFO full and no pop in the same cycle is dropped and counted.
module fir_out_requant_fifo #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 6,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [IN_WIDTH-1:0]        in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sat_flag,
  output logic [15:0]                sat_count,
  output logic                       ovf_flag,
  output logic [15:0]                drop_count,
  output logic [OUT_WIDTH-1:0]       peak_abs
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = IN_WIDTH + 1 - SHIFT;
  localparam logic [IN_WIDTH:0]    HALF    = (IN_WIDTH + 1)'(1) << (SHIFT - 1);
  localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MAX_NEG = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  // ---------------- stage 1: round, shift, saturate ----------------
  logic [IN_WIDTH:0]      rounded;
  logic [QW-1:0]          q;
  logic [QW-OUT_WIDTH:0]  q_top;
  logic                   q_fits;

  // One extra bit keeps the rounding add from wrapping on the most positive input.
  assign rounded = {in_data[IN_WIDTH-1], in_data} + HALF;
  // Taking the upper bits of a two's-complement value is an arithmetic shift.
  assign q       = rounded[IN_WIDTH:SHIFT];
  // The value fits the output when every bit from the output sign bit up is
  // a copy of the sign.
  assign q_top   = q[QW-1:OUT_WIDTH-1];
  assign q_fits  = (&q_top) | ~(|q_top);

  logic                 s1_valid;
  logic                 s1_sat;
  logic [OUT_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_sat   <= in_valid & ~q_fits;
      s1_data  <= q_fits ? q[OUT_WIDTH-1:0] : (q[QW-1] ? MAX_NEG : MAX_POS);
    end
  end

  // ---------------- stage 2: FIFO ----------------
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  // The pointers wrap modulo 2*DEPTH, so their difference is the occupancy.
  assign level     = wr_ptr - rd_ptr;
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push      = s1_valid & (~full | pop);
  assign drop      = s1_valid & ~push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= s1_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- status ----------------
  logic [OUT_WIDTH-1:0] s1_abs;

  always_comb begin
    s1_abs = s1_data;
    if (s1_data[OUT_WIDTH-1]) begin
      s1_abs = (s1_data == MAX_NEG) ? MAX_POS : (~s1_data + OUT_WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag   <= 1'b0;
      sat_count  <= '0;
      ovf_flag   <= 1'b0;
      drop_count <= '0;
      peak_abs   <= '0;
    end else if (clear) begin
      sat_flag   <= 1'b0;
      sat_count  <= '0;
      ovf_flag   <= 1'b0;
      drop_count <= '0;
      peak_abs   <= '0;
    end else begin
      // Saturation is counted whether or not the sample makes it into the FIFO.
      if (s1_valid && s1_sat) begin
        sat_flag <= 1'b1;
        if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      end
      if (drop) begin
        ovf_flag <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (push && (s1_abs > peak_abs)) peak_abs <= s1_abs;
    end
  end

endmodule
